mem_resp_slave: RTL and testbench
=================================

Name: mem_resp_slave

Overview:
- Responder (memory side) of the CPU load/store request/acknowledge handshake.
- Accepts one word-aligned read or write request from the MEM stage.
- Holds it for a programmable number of wait states, then returns a single-cycle acknowledge carrying read data or a fault flag.
- Backed by an internal word-organised RAM with byte enables. Serves as the on-chip data memory in simulation and FPGA builds.

Parameters:
- MEM_WORDS, 1024, depth of the internal RAM in 32-bit words; must be a power of 2.
- WAIT_STATES, 1, cycles inserted between acceptance and acknowledge; legal range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to MEM_WORDS*4.

Ports:
- clk_in  input  1  system clock, rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- req_valid_in  input  1  request present.
- req_ready_out  output  1  responder can accept a request this cycle.
- req_wr_in  input  1  1 = write, 0 = read.
- req_addr_in  input  32  byte address.
- req_wr_data_in  input  32  write data.
- req_be_in  input  4  byte enables; bit n selects bits 8n+7:8n.
- ack_out  output  1  one-cycle response strobe.
- rd_data_out  output  32  read data, valid with ack_out.
- fault_out  output  1  access fault, valid with ack_out.

Behaviour:
- Reset: the clock and reset are as already decided (one clock; reset is asynchronous and active-low).
- Reset values of outputs:
  - req_ready_out = FALSE, then TRUE on the first clock after reset deassertion.
  - ack_out = FALSE, rd_data_out = 0, fault_out = FALSE.
  - State = IDLE, wait counter = 0.
  - RAM contents are not reset.
- Acceptance occurs when req_valid_in && req_ready_out are both high at a rising edge. The request fields are latched on that edge.
- Fault conditions (fault = TRUE):
  - req_addr_in[1:0] != 0, or
  - the address lies outside BASE_ADDR .. BASE_ADDR + MEM_WORDS*4 - 1, or
  - req_be_in == 0.
- Word index = (addr - BASE_ADDR) >> 2, truncated to log2(MEM_WORDS) bits.
- State machine:
  - IDLE: req_ready_out = TRUE. On acceptance, go to WAIT if WAIT_STATES > 0 and load the counter with WAIT_STATES-1; otherwise go to RESP.
  - WAIT: req_ready_out = FALSE. Decrement the counter each cycle; when the counter is 0, go to RESP.
  - RESP: req_ready_out = FALSE. ack_out = TRUE for exactly one cycle, then go to IDLE.
- Latency: ack_out rises WAIT_STATES+1 cycles after the acceptance edge.
- Throughput: one request per WAIT_STATES+2 cycles.
- Write commit: only on the clock edge that enters RESP, only when there is no fault, and only on enabled bytes.
- Response data:
  - Reads: rd_data_out = full 32-bit stored word, with byte enables ignored for data.
  - Writes: rd_data_out = 0.
  - Faulted access: rd_data_out = 0, no RAM update.
- rd_data_out and fault_out return to 0 in every cycle where ack_out is FALSE.
- Inputs are ignored outside IDLE; changes to req_* during WAIT have no effect.
- Reset mid-operation (reset_n_in low while in WAIT or RESP):
  - immediate return to IDLE with outputs at reset values;
  - a write still in WAIT is never committed.
- Read-after-write: a read accepted after a write's ack returns the new data.

Optional Feature:
- Macro: MEM_RESP_STATS_EN.
- When defined:
  - Adds outputs rd_cnt_out[31:0], wr_cnt_out[31:0] and fault_cnt_out[31:0].
  - Each counts acknowledged reads, acknowledged non-faulted writes and faulted accesses respectively.
  - Each increments on the RESP cycle, wraps at 2^32 and is reset to 0.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- mem_resp_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_t;
  - a packed struct mem_req_t {wr, addr, wr_data, be};
  - constant WAIT_CNT_W = 4.
- TRUE/FALSE come from the existing logic_params_pkg.
- One sub-module, mem_resp_ram: a single-port byte-enabled synchronous RAM. It has registered read and a write gated by a commit strobe. The FSM in mem_resp_slave drives it.

Test Plan:
- Reset mid-operation: WAIT_STATES=3, write 32'hCAFE_F00D to 0x8, then pull reset_n_in low one cycle after acceptance → no ack; a subsequent read of 0x8 returns the prior contents (not 32'hCAFE_F00D).
- Basic write/read: WAIT_STATES=1, write 32'hDEAD_BEEF with be=4'hF to 0x10 → ack 2 cycles after acceptance with fault=0, rd_data=0; then read 0x10 → ack after 2 cycles with rd_data=32'hDEAD_BEEF.
- Byte enables: write 32'h1122_3344 with be=4'b0101 over 32'hFFFF_FFFF at 0x20 → read returns 32'hFF22_FF44.
- Faults: read 0x13 (misaligned), read BASE_ADDR+MEM_WORDS*4 (out of range), write with be=0 → each acks with fault=1 and rd_data=0; RAM unchanged.
- Zero wait / back-to-back: WAIT_STATES=0, hold req_valid_in high for 4 reads → acks on cycles 1, 3, 5, 7 after the first acceptance; req_ready_out low on the ack cycles; inputs changed during RESP are ignored.
- Stats (with MEM_RESP_STATS_EN): after the above sequence → counters match issued reads, non-faulted writes and faults exactly; all counters are 0 after reset.

Source files
------------

// File: rtl/logic_params_pkg.sv
// Shared single-bit truth constants used across the core.
package logic_params_pkg;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
endpackage

// File: rtl/mem_resp_pkg.sv
// Types and constants shared by the memory responder and its RAM.
package mem_resp_pkg;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_resp_state_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wr_data;
        logic [3:0]  be;
    } mem_req_t;
endpackage

// File: rtl/mem_resp_ram.sv
// Single-port word RAM: byte-enabled write on commit strobe, registered read on i_rd_en.
// Read data appears the cycle after i_rd_en and holds until the next read; contents are never reset.
module mem_resp_ram #(
    parameter int WORDS = 1024,
    parameter int IDX_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rd_en,
    input  logic             i_wr_commit,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wr_dat,
    input  logic [3:0]       i_be,
    output logic [31:0]      o_rd_dat
);
    logic [31:0] r_mem [WORDS];
    logic [31:0] r_rd_dat;

    always_ff @(posedge i_clk) begin
        if (i_wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wr_dat[8*b +: 8];
                end
            end
        end
        if (i_rd_en) begin
            r_rd_dat <= r_mem[i_idx];
        end
    end

    assign o_rd_dat = r_rd_dat;
endmodule

// File: rtl/mem_resp_slave.sv
// Memory-side load/store responder: one request in flight, ack WAIT_STATES+1 cycles after acceptance,
// ready only while idle. Optional access counters under MEM_RESP_STATS_EN.
module mem_resp_slave
    import mem_resp_pkg::*;
    import logic_params_pkg::*;
#(
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_wr_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wr_data_in,
    input  logic [3:0]  req_be_in,
    output logic        ack_out,
    output logic [31:0] rd_data_out,
    output logic        fault_out
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0] rd_cnt_out,
    output logic [31:0] wr_cnt_out,
    output logic [31:0] fault_cnt_out
`endif
);
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    mem_resp_state_t       r_state;
    mem_resp_state_t       w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [WAIT_CNT_W-1:0] w_cnt_nxt;
    logic                  r_live;
    logic                  r_wr;
    logic                  r_fault;
    logic [IDX_W-1:0]      r_idx;
    logic [31:0]           r_wdat;
    logic [3:0]            r_be;

    mem_req_t              w_req;
    logic [31:0]           w_off;
    logic                  w_in_range;
    logic                  w_fault;
    logic [IDX_W-1:0]      w_idx_in;
    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_use_in;
    logic                  w_cur_wr;
    logic                  w_cur_fault;
    logic [IDX_W-1:0]      w_ram_idx;
    logic [31:0]           w_ram_wdat;
    logic [3:0]            w_ram_be;
    logic                  w_commit;
    logic [31:0]           w_ram_rd;

    assign w_req.wr      = req_wr_in;
    assign w_req.addr    = req_addr_in;
    assign w_req.wr_data = req_wr_data_in;
    assign w_req.be      = req_be_in;

    // Unsigned offset wraps for addresses below the base, so one compare covers both ends.
    assign w_off      = w_req.addr - BASE_ADDR;
    assign w_in_range = ({1'b0, w_off} < (33'(MEM_WORDS) << 2));
    assign w_fault    = (w_req.addr[1:0] != 2'b00) || !w_in_range || (w_req.be == 4'b0000);
    assign w_idx_in   = w_off[IDX_W+1:2];

    assign req_ready_out = r_live && (r_state == IDLE);
    assign w_accept      = req_valid_in && req_ready_out;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = FALSE;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES > 0) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = WAIT_CNT_W'(WAIT_STATES - 1);
                    end else begin
                        w_state_nxt  = RESP;
                        w_enter_resp = TRUE;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = RESP;
                    w_enter_resp = TRUE;
                end else begin
                    w_cnt_nxt = r_cnt - WAIT_CNT_W'(1);
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_live  <= FALSE;
            r_wr    <= FALSE;
            r_fault <= FALSE;
            r_idx   <= '0;
            r_wdat  <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_live  <= TRUE;
            if (w_accept) begin
                r_wr    <= w_req.wr;
                r_fault <= w_fault;
                r_idx   <= w_idx_in;
                r_wdat  <= w_req.wr_data;
                r_be    <= w_req.be;
            end
        end
    end

    // With zero wait states the commit edge is the acceptance edge, so the RAM sees live inputs in IDLE.
    assign w_use_in    = (r_state == IDLE);
    assign w_cur_wr    = w_use_in ? w_req.wr      : r_wr;
    assign w_cur_fault = w_use_in ? w_fault       : r_fault;
    assign w_ram_idx   = w_use_in ? w_idx_in      : r_idx;
    assign w_ram_wdat  = w_use_in ? w_req.wr_data : r_wdat;
    assign w_ram_be    = w_use_in ? w_req.be      : r_be;
    assign w_commit    = w_enter_resp && w_cur_wr && !w_cur_fault;

    mem_resp_ram #(
        .WORDS(MEM_WORDS),
        .IDX_W(IDX_W)
    ) u_ram (
        .i_clk       (clk_in),
        .i_rd_en     (w_accept),
        .i_wr_commit (w_commit),
        .i_idx       (w_ram_idx),
        .i_wr_dat    (w_ram_wdat),
        .i_be        (w_ram_be),
        .o_rd_dat    (w_ram_rd)
    );

    assign ack_out     = (r_state == RESP);
    assign fault_out   = ack_out && r_fault;
    assign rd_data_out = (ack_out && !r_fault && !r_wr) ? w_ram_rd : 32'h0;

`ifdef MEM_RESP_STATS_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;
    logic [31:0] r_flt_cnt;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_flt_cnt <= '0;
        end else if (ack_out) begin
            if (!r_wr)            r_rd_cnt  <= r_rd_cnt + 32'd1;
            if (r_wr && !r_fault) r_wr_cnt  <= r_wr_cnt + 32'd1;
            if (r_fault)          r_flt_cnt <= r_flt_cnt + 32'd1;
        end
    end

    assign rd_cnt_out    = r_rd_cnt;
    assign wr_cnt_out    = r_wr_cnt;
    assign fault_cnt_out = r_flt_cnt;
`endif
endmodule

// File: tb/tb_mem_resp_slave.sv
// Directed bench: three responders with 0, 1 and 3 wait states sharing clock and reset.
`timescale 1ns/1ps
module tb_mem_resp_slave;
    localparam int          N  = 3;
    localparam int          MW = 64;
    localparam logic [31:0] B  = 32'h0000_0100;
    localparam int          NV = 21;

    function automatic int ws_of(input int g);
        return (g == 0) ? 0 : (g == 1) ? 1 : 3;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v   [N];
    logic        wr  [N];
    logic [31:0] addr[N];
    logic [31:0] wd  [N];
    logic [3:0]  be  [N];
    logic        rdy [N];
    logic        ack [N];
    logic        flt [N];
    logic [31:0] rd  [N];
`ifdef MEM_RESP_STATS_EN
    logic [31:0] c_rd[N];
    logic [31:0] c_wr[N];
    logic [31:0] c_fl[N];
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int m_rd[N];
    int m_wr[N];
    int m_fl[N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_resp_slave #(
            .MEM_WORDS  (MW),
            .WAIT_STATES(ws_of(g)),
            .BASE_ADDR  (B)
        ) u_dut (
            .clk_in        (clk),
            .reset_n_in    (rst_n),
            .req_valid_in  (v[g]),
            .req_ready_out (rdy[g]),
            .req_wr_in     (wr[g]),
            .req_addr_in   (addr[g]),
            .req_wr_data_in(wd[g]),
            .req_be_in     (be[g]),
            .ack_out       (ack[g]),
            .rd_data_out   (rd[g]),
            .fault_out     (flt[g])
`ifdef MEM_RESP_STATS_EN
            ,
            .rd_cnt_out    (c_rd[g]),
            .wr_cnt_out    (c_wr[g]),
            .fault_cnt_out (c_fl[g])
`endif
        );
    end

    typedef struct {
        int          u;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic        ef;
        logic [31:0] er;
    } vec_t;

    vec_t tv[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        for (int u = 0; u < N; u++) begin
            chk($sformatf("%s u%0d ready", nm, u), 32'(rdy[u]), 32'd0);
            chk($sformatf("%s u%0d ack", nm, u), 32'(ack[u]), 32'd0);
            chk($sformatf("%s u%0d rd_data", nm, u), rd[u], 32'd0);
            chk($sformatf("%s u%0d fault", nm, u), 32'(flt[u]), 32'd0);
        end
    endtask

    task automatic chk_stats(input string nm);
`ifdef MEM_RESP_STATS_EN
        for (int u = 0; u < N; u++) begin
            chk($sformatf("%s u%0d rd_cnt", nm, u), c_rd[u], 32'(m_rd[u]));
            chk($sformatf("%s u%0d wr_cnt", nm, u), c_wr[u], 32'(m_wr[u]));
            chk($sformatf("%s u%0d fault_cnt", nm, u), c_fl[u], 32'(m_fl[u]));
        end
`else
        if (nm.len() == 0) $display("stats disabled");
`endif
    endtask

    task automatic clear_model();
        for (int u = 0; u < N; u++) begin
            m_rd[u] = 0;
            m_wr[u] = 0;
            m_fl[u] = 0;
        end
    endtask

    // Issue one request, then scramble the request fields while it is in flight.
    task automatic do_req(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic ef, input logic [31:0] er, input string nm);
        int lat;
        int guard;
        bit got;
        @(negedge clk);
        guard = 0;
        while (!rdy[u] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({nm, " ready"}, 32'(rdy[u]), 32'd1);
        wr[u] = w; addr[u] = a; wd[u] = d; be[u] = b; v[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v[u] = 1'b0; wr[u] = ~w; addr[u] = ~a; wd[u] = ~d; be[u] = ~b;
        lat = 1;
        got = 1'b0;
        while (!got && lat <= 20) begin
            if (ack[u]) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk({nm, " ack seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({nm, " latency"}, 32'(lat), 32'(ws_of(u) + 1));
            chk({nm, " fault"}, 32'(flt[u]), 32'(ef));
            chk({nm, " rd_data"}, rd[u], er);
            chk({nm, " ready during ack"}, 32'(rdy[u]), 32'd0);
            @(negedge clk);
            chk({nm, " ack one cycle"}, 32'(ack[u]), 32'd0);
            chk({nm, " rd_data after ack"}, rd[u], 32'd0);
            chk({nm, " fault after ack"}, 32'(flt[u]), 32'd0);
        end
        if (!w) m_rd[u]++;
        if (ef) m_fl[u]++;
        else if (w) m_wr[u]++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tv[0]  = '{1, 1'b1, B + 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
        tv[1]  = '{1, 1'b0, B + 32'h10, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};
        tv[2]  = '{1, 1'b1, B + 32'h20, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
        tv[3]  = '{1, 1'b1, B + 32'h20, 32'h1122_3344, 4'h5, 1'b0, 32'h0};
        tv[4]  = '{1, 1'b0, B + 32'h20, 32'h0,         4'hF, 1'b0, 32'hFF22_FF44};
        tv[5]  = '{1, 1'b0, B + 32'h13, 32'h0,         4'hF, 1'b1, 32'h0};
        tv[6]  = '{1, 1'b0, B + 32'h100, 32'h0,        4'hF, 1'b1, 32'h0};
        tv[7]  = '{1, 1'b1, B + 32'h20, 32'h0,         4'h0, 1'b1, 32'h0};
        tv[8]  = '{1, 1'b1, B + 32'h21, 32'h0,         4'hF, 1'b1, 32'h0};
        tv[9]  = '{1, 1'b0, B + 32'h20, 32'h0,         4'hF, 1'b0, 32'hFF22_FF44};
        tv[10] = '{1, 1'b0, B - 32'h4,  32'h0,         4'hF, 1'b1, 32'h0};
        tv[11] = '{1, 1'b1, B + 32'hFC, 32'hA5A5_5A5A, 4'hF, 1'b0, 32'h0};
        tv[12] = '{1, 1'b1, B + 32'hFC, 32'h0000_00C3, 4'h1, 1'b0, 32'h0};
        tv[13] = '{1, 1'b0, B + 32'hFC, 32'h0,         4'hF, 1'b0, 32'hA5A5_5AC3};
        tv[14] = '{0, 1'b1, B + 32'h0,  32'h0000_0A00, 4'hF, 1'b0, 32'h0};
        tv[15] = '{0, 1'b1, B + 32'h4,  32'h0000_0A04, 4'hF, 1'b0, 32'h0};
        tv[16] = '{0, 1'b1, B + 32'h8,  32'h0000_0A08, 4'hF, 1'b0, 32'h0};
        tv[17] = '{0, 1'b1, B + 32'hC,  32'h0000_0A0C, 4'hF, 1'b0, 32'h0};
        tv[18] = '{0, 1'b0, B + 32'h4,  32'h0,         4'hF, 1'b0, 32'h0000_0A04};
        tv[19] = '{2, 1'b1, B + 32'h8,  32'h1234_5678, 4'hF, 1'b0, 32'h0};
        tv[20] = '{2, 1'b0, B + 32'h8,  32'h0,         4'hF, 1'b0, 32'h1234_5678};

        for (int u = 0; u < N; u++) begin
            v[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; wd[u] = '0; be[u] = '0;
        end
        clear_model();

        // Power-on reset: outputs quiet, ready only after the first clock out of reset.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk_stats("reset");
        rst_n = 1'b1;
        #1;
        for (int u = 0; u < N; u++) chk($sformatf("release u%0d ready", u), 32'(rdy[u]), 32'd0);
        @(negedge clk);
        for (int u = 0; u < N; u++) chk($sformatf("first clk u%0d ready", u), 32'(rdy[u]), 32'd1);

        for (int i = 0; i < NV; i++) begin
            do_req(tv[i].u, tv[i].w, tv[i].a, tv[i].d, tv[i].b, tv[i].ef, tv[i].er, $sformatf("vec%0d", i));
        end

        // Zero-wait back-to-back reads with valid held high; fields scrambled during each ack.
        @(negedge clk);
        wr[0] = 1'b0; addr[0] = B; be[0] = 4'hF; wd[0] = '0; v[0] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            logic exp_ack;
            @(negedge clk);
            exp_ack = (c % 2) == 1;
            chk($sformatf("b2b c%0d ack", c), 32'(ack[0]), 32'(exp_ack));
            chk($sformatf("b2b c%0d ready", c), 32'(rdy[0]), 32'(!exp_ack));
            if (exp_ack) begin
                chk($sformatf("b2b c%0d rd_data", c), rd[0], 32'h0A00 + 32'(4 * ((c - 1) / 2)));
                wr[0] = 1'b1; addr[0] = B; wd[0] = 32'hBAD0_BAD0;
            end else if (c == 8) begin
                v[0] = 1'b0;
            end else begin
                wr[0] = 1'b0; addr[0] = B + 32'(4 * (c / 2)); wd[0] = '0;
            end
        end
        m_rd[0] += 4;
        do_req(0, 1'b0, B, 32'h0, 4'hF, 1'b0, 32'h0000_0A00, "b2b word0 intact");
        chk_stats("stats before midop");

        // Reset while a write waits: nothing acks and the old word survives.
        @(negedge clk);
        wr[2] = 1'b1; addr[2] = B + 32'h8; wd[2] = 32'hCAFE_F00D; be[2] = 4'hF; v[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v[2] = 1'b0;
        chk("midop waiting ack", 32'(ack[2]), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midop reset");
        clear_model();
        chk_stats("stats after midop reset");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("midop hold%0d ack", k), 32'(ack[2]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("midop ready after release", 32'(rdy[2]), 32'd1);
        do_req(2, 1'b0, B + 32'h8, 32'h0, 4'hF, 1'b0, 32'h1234_5678, "midop readback");
        do_req(1, 1'b0, B + 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, "ram kept over reset");
        do_req(1, 1'b1, B + 32'h13, 32'h0, 4'hF, 1'b1, 32'h0, "faulted write after reset");
        chk_stats("stats final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
